// File: rtl/seq_det_pkg.sv
// Shared definitions for the sequence-match monitor.
// Holds the monitor FSM state type and the default values of the monitor parameters.
package seq_det_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StReport = 2'd2
  } mon_state_e;

  localparam int unsigned WinLenDefault = 256;
  localparam int unsigned CntWDefault   = 16;
  localparam int unsigned ThreshDefault = 4;

endpackage

// File: rtl/seq_win_timer.sv
// Window timer for the sequence-match monitor.
// Counts RUN cycles from 0 up to WIN_LEN-1, then wraps back to 0 for the next window.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   run  - count this cycle (monitor is in RUN and enabled); low zeroes the timer
//   clr  - synchronous clear, zeroes the timer
//   last - high while the timer equals WIN_LEN-1 (final cycle of the window)
module seq_win_timer
  import seq_det_pkg::*;
#(
  parameter int unsigned WIN_LEN = WinLenDefault
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clr,
  output logic last
);

  localparam int unsigned TimerW = $clog2(WIN_LEN);

  logic [TimerW-1:0] cnt_q;

  assign last = (cnt_q == TimerW'(WIN_LEN - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr || !run || last) begin
      // Leaving RUN, aborting, or completing a window all restart the count at 0.
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + TimerW'(1);
    end
  end

endmodule

// File: rtl/seq_match_monitor.sv
// Sequence-match monitor: counts detector matches over fixed windows of WIN_LEN RUN cycles,
// reports each completed window's count, keeps a saturating total and a sticky threshold alarm.
// Optional feature: define SEQ_MON_ALARM_EN to build the alarm comparator/register; otherwise
// alarm is tied to 0.
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous active-high reset
//   en        - monitoring enable; dropping it mid-window aborts that window
//   clear     - synchronous clear of counters, alarm and FSM; wins over everything else
//   det_in    - detector match, one match per high cycle (counted only in enabled RUN cycles)
//   total_cnt - saturating count of all matches since reset/clear
//   win_cnt   - match count of the last completed window
//   win_valid - one-cycle pulse when win_cnt is loaded
//   alarm     - sticky flag, set when a completed window holds at least THRESH matches
// A RUN cycle with en low is treated as the abort cycle: its det_in is not counted, and this
// applies to the last window cycle as well.
module seq_match_monitor
  import seq_det_pkg::*;
#(
  parameter int unsigned WIN_LEN = WinLenDefault,
  parameter int unsigned CNT_W   = CntWDefault,
  parameter int unsigned THRESH  = ThreshDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic             det_in,
  output logic [CNT_W-1:0] total_cnt,
  output logic [CNT_W-1:0] win_cnt,
  output logic             win_valid,
  output logic             alarm
);

  mon_state_e       state;
  logic [CNT_W-1:0] run_cnt;
  logic             active;
  logic             last;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign active = (state == StRun) && en;

  seq_win_timer #(
    .WIN_LEN(WIN_LEN)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .run (active),
    .clr (clear),
    .last(last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      run_cnt   <= '0;
      total_cnt <= '0;
      win_cnt   <= '0;
      win_valid <= 1'b0;
    end else begin
      win_valid <= 1'b0;
      if (clear) begin
        state     <= StIdle;
        run_cnt   <= '0;
        total_cnt <= '0;
        win_cnt   <= '0;
      end else begin
        unique case (state)
          StIdle: begin
            if (en) state <= StRun;
          end
          StRun: begin
            if (!en) begin
              state   <= StIdle;
              run_cnt <= '0;
            end else begin
              if (det_in) total_cnt <= sat_inc(total_cnt);
              if (last) begin
                // Final window cycle: its own match is folded into the reported count.
                state     <= StReport;
                win_cnt   <= det_in ? sat_inc(run_cnt) : run_cnt;
                win_valid <= 1'b1;
                run_cnt   <= '0;
              end else if (det_in) begin
                run_cnt <= sat_inc(run_cnt);
              end
            end
          end
          StReport: begin
            state <= en ? StRun : StIdle;
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

`ifdef SEQ_MON_ALARM_EN
  logic alarm_q;

  // Evaluated during the REPORT cycle, so win_cnt already holds the just-completed window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alarm_q <= 1'b0;
    end else if (clear) begin
      alarm_q <= 1'b0;
    end else if ((state == StReport) && (32'(win_cnt) >= THRESH)) begin
      alarm_q <= 1'b1;
    end
  end

  assign alarm = alarm_q;
`else
  logic unused_thresh;
  assign unused_thresh = ^THRESH;
  assign alarm         = 1'b0;
`endif

endmodule
